data_memory_sized: RTL



---
 rtl/data_memory_sized.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian MEM-stage data memory with a post-reset clear sequencer and fault capture.
// Optional macro DMEM_DEBUG_PORT_EN adds a combinational word-wide debug read port.
module data_memory_sized #(
    parameter int DEPTH_BYTES    = 256,
    parameter int ADDR_WIDTH     = 64,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [63:0]           Write_Data,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [2:0]            Funct3,
    output logic [63:0]           Read_Data,
    output logic                  Busy,
    output logic                  Fault,
    output logic [ADDR_WIDTH-1:0] Fault_Addr,
    output logic [CNT_WIDTH-1:0]  Fault_Count
`ifdef DMEM_DEBUG_PORT_EN
    ,
    input  logic [$clog2(DEPTH_BYTES)-4:0] Dbg_Addr,
    output logic [63:0]                    Dbg_Data
`endif
);

    localparam int BYTE_AW = $clog2(DEPTH_BYTES);
    localparam int IDX_W   = BYTE_AW - 3;
    localparam int WORDS   = DEPTH_BYTES / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] clr_idx_reg;
    logic             busy, clear_we;

    logic                  fault_reg, first_seen_reg;
    logic [ADDR_WIDTH-1:0] fault_addr_reg;
    logic [CNT_WIDTH-1:0]  fault_count_reg;

    logic [1:0]            size_log;
    logic [3:0]            size_bytes;
    logic [7:0]            byte_mask, be;
    logic                  misalign, in_range, funct_ok, legal;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  fault_now, store_we, load_ok;
    logic [IDX_W-1:0]      acc_idx;
    logic [63:0]           wdata_sh, rd_word, rd_sh, rd_ext;

    // State register: clr_idx is the word index of the next 8-byte block to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CLEAR)
                clr_idx_reg <= clr_idx_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == CLEAR && clr_idx_reg == IDX_W'(WORDS - 1))
            state_next = READY;
    end

    always_comb begin
        busy     = (state_reg == CLEAR);
        clear_we = busy & ~reset;
    end

    // Access decode; range check is done one bit wider so a huge address cannot wrap into range.
    always_comb begin
        size_log   = Funct3[1:0];
        size_bytes = 4'd1 << size_log;
        case (size_log)
            2'd0:    begin byte_mask = 8'h01; misalign = 1'b0;           end
            2'd1:    begin byte_mask = 8'h03; misalign = Mem_Addr[0];    end
            2'd2:    begin byte_mask = 8'h0F; misalign = |Mem_Addr[1:0]; end
            default: begin byte_mask = 8'hFF; misalign = |Mem_Addr[2:0]; end
        endcase
        end_addr  = {1'b0, Mem_Addr} + {{(ADDR_WIDTH-3){1'b0}}, size_bytes};
        in_range  = (end_addr <= (ADDR_WIDTH+1)'(DEPTH_BYTES));
        funct_ok  = MemWrite ? ~Funct3[2] : (Funct3 != 3'b111);
        legal     = funct_ok & ~misalign & in_range & ~(MemRead & MemWrite);
        fault_now = (MemRead | MemWrite) & ~busy & ~legal;
        store_we  = MemWrite & ~MemRead & ~busy & legal & ~reset;
        load_ok   = MemRead & ~MemWrite & ~busy & legal;
        acc_idx   = Mem_Addr[BYTE_AW-1:3];
        be        = byte_mask << Mem_Addr[2:0];
        wdata_sh  = Write_Data << {Mem_Addr[2:0], 3'b000};
    end

    // One byte-wide array per lane so narrow stores need no read-modify-write.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            always_ff @(posedge clk) begin
                if (clear_we)
                    lane_mem[clr_idx_reg] <= 8'h00;
                else if (store_we && be[gi])
                    lane_mem[acc_idx] <= wdata_sh[8*gi +: 8];
            end
            assign rd_word[8*gi +: 8] = lane_mem[acc_idx];
`ifdef DMEM_DEBUG_PORT_EN
            assign Dbg_Data[8*gi +: 8] = lane_mem[Dbg_Addr];
`endif
        end
    endgenerate

    always_comb begin
        rd_sh = rd_word >> {Mem_Addr[2:0], 3'b000};
        case (Funct3)
            3'b000:  rd_ext = {{56{rd_sh[7]}},  rd_sh[7:0]};
            3'b001:  rd_ext = {{48{rd_sh[15]}}, rd_sh[15:0]};
            3'b010:  rd_ext = {{32{rd_sh[31]}}, rd_sh[31:0]};
            3'b011:  rd_ext = rd_sh;
            3'b100:  rd_ext = {56'd0, rd_sh[7:0]};
            3'b101:  rd_ext = {48'd0, rd_sh[15:0]};
            3'b110:  rd_ext = {32'd0, rd_sh[31:0]};
            default: rd_ext = 64'd0;
        endcase
        Read_Data = load_ok ? rd_ext : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_reg       <= 1'b0;
            fault_addr_reg  <= '0;
            fault_count_reg <= '0;
            first_seen_reg  <= 1'b0;
        end else begin
            fault_reg <= fault_now;
            if (fault_now) begin
                if (fault_count_reg != '1)
                    fault_count_reg <= fault_count_reg + 1'b1;
                if (!first_seen_reg) begin
                    fault_addr_reg <= Mem_Addr;
                    first_seen_reg <= 1'b1;
                end
            end
        end
    end

    assign Busy        = busy;
    assign Fault       = fault_reg;
    assign Fault_Addr  = fault_addr_reg;
    assign Fault_Count = fault_count_reg;

endmodule
